// File: rtl/hazard_stall_ctrl_if.sv
// Purpose: groups the pipeline-side hazard inputs and the buffer control
//          outputs of hazard_stall_ctrl into one bundle.
// Signals:
//   id_rs1, id_rs2, ex_rd          register addresses (REG_AW bits)
//   ex_mem_read, branch_taken      EX-stage status
//   halt_id                        HLT decoded in ID
//   mem_req, mem_ready             MEM-stage access handshake
//   pc_en, *_en, *_flush           PC / buffer load enables and bubble requests
//   halted, mem_err, stall_cycles  status
// Modports: master = pipeline side (drives hazard inputs),
//           slave  = controller side (drives enables/flushes/status).
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 3
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              branch_taken;
  logic              halt_id;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              memwb_flush;
  logic              halted;
  logic              mem_err;
  logic [15:0]       stall_cycles;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, halt_id,
           mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, mem_err, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, halt_id,
           mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Purpose: hazard / stall sequencer for a 5-stage pipeline. Drives the PC
//          enable and the IF/ID, ID/EX, EX/MEM, MEM/WB buffer enables and
//          flushes for load-use stalls, taken-branch flushes, memory waits
//          (with timeout) and the HLT drain.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous active-low reset
//   bus    hazard_stall_ctrl_if.slave (hazard inputs in, controls/status out)
//
// State table:
//   ST_RUN      | normal issue; load-use / branch / halt handling
//   ST_MEM_WAIT | pipeline frozen waiting on mem_ready; returns to RUN or DRAIN
//   ST_DRAIN    | fetch stopped, in-flight instructions retire
//   ST_HALTED   | everything frozen; left only through reset
module hazard_stall_ctrl #(
  parameter int REG_AW       = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int TO_W         = 8
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TO_W-1:0] WAIT_LAST  = TO_W'(MEM_TIMEOUT);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              ret_drain_q, ret_drain_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [15:0]       stall_q;

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              mem_stall, load_use;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl;

  assign rs1       = bus.id_rs1;
  assign rs2       = bus.id_rs2;
  assign rd        = bus.ex_rd;
  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign load_use  = bus.ex_mem_read & ((rd == rs1) | (rd == rs2));

  always_comb begin
    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_fl     = 1'b0;
    idex_fl     = 1'b0;
    exmem_fl    = 1'b0;
    memwb_fl    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_fl    = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = TO_W'(1);
          ret_drain_d = 1'b0;
        end else if (bus.branch_taken) begin
          // halt_id here belongs to a wrong-path instruction and dies with it
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
        end else if (load_use) begin
          // halt_id, if present, is held in ID and seen again next cycle
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_fl = 1'b1;
        end else if (bus.halt_id) begin
          pc_en       = 1'b0;
          ifid_fl     = 1'b1;
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          if (ret_drain_q) begin
            pc_en   = 1'b0;
            ifid_fl = 1'b1;
          end
          state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_fl = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = ST_HALTED;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_stall) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_fl    = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = TO_W'(1);
          ret_drain_d = 1'b1;
        end else begin
          pc_en   = 1'b0;
          ifid_fl = 1'b1;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      ST_HALTED: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end
      default: state_d = ST_RUN;
    endcase

    if (!reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_fl, idex_fl, exmem_fl, memwb_fl}        = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_drain_q <= 1'b0;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mem_err_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
      if (!pc_en && state_q != ST_HALTED && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  // A flushed buffer is never also loaded, so each en is masked by its flush.
  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en  & ~ifid_fl;
  assign bus.idex_en      = idex_en  & ~idex_fl;
  assign bus.exmem_en     = exmem_en & ~exmem_fl;
  assign bus.memwb_en     = memwb_en & ~memwb_fl;
  assign bus.ifid_flush   = ifid_fl;
  assign bus.idex_flush   = idex_fl;
  assign bus.exmem_flush  = exmem_fl;
  assign bus.memwb_flush  = memwb_fl;
  assign bus.halted       = reset & (state_q == ST_HALTED);
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_q;

endmodule
